// File: rtl/jerky_pkg.sv
// Shared types and mode encodings for the parametrised jerky counter.
package jerky_pkg;

  localparam logic [1:0] MODE_UP_ENC    = 2'b00;
  localparam logic [1:0] MODE_JERKY_ENC = 2'b01;
  localparam logic [1:0] MODE_DOWN_ENC  = 2'b10;
  localparam logic [1:0] MODE_HOLD_ENC  = 2'b11;

  typedef enum logic [1:0] {
    MODE_UP    = MODE_UP_ENC,
    MODE_JERKY = MODE_JERKY_ENC,
    MODE_DOWN  = MODE_DOWN_ENC,
    MODE_HOLD  = MODE_HOLD_ENC
  } mode_t;

  typedef enum logic {
    PH_FWD  = 1'b0,
    PH_BACK = 1'b1
  } phase_t;

endpackage

// File: rtl/jerky_step.sv
// Combinational step: next count value and wrap flag for the selected mode.
module jerky_step
  import jerky_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned JUMP  = 3,
  parameter int unsigned BACK  = 1
) (
  input  logic [WIDTH-1:0] count,
  input  mode_t            mode,
  input  phase_t           phase,
  output logic [WIDTH-1:0] next_count_c,
  output logic             next_wrap_c
);

  localparam int unsigned XW = WIDTH + 1;

  logic [XW-1:0] ext;

  // One extra bit catches both carry-out and borrow on every step.
  always_comb begin
    ext = {1'b0, count};
    unique case (mode)
      MODE_UP:    ext = {1'b0, count} + XW'(1);
      MODE_DOWN:  ext = {1'b0, count} - XW'(1);
      MODE_JERKY: ext = (phase == PH_FWD) ? ({1'b0, count} + XW'(JUMP))
                                          : ({1'b0, count} - XW'(BACK));
      MODE_HOLD:  ext = {1'b0, count};
      default:    ext = {1'b0, count};
    endcase
    next_count_c = ext[WIDTH-1:0];
    next_wrap_c  = ext[WIDTH];
  end

endmodule

// File: rtl/jerky_counter_param.sv
// Free-running counter with up/jerky/down/hold modes, load, enable,
// a jerky phase indicator and a one-cycle wrap pulse.
module jerky_counter_param
  import jerky_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned JUMP  = 3,
  parameter int unsigned BACK  = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             phase,
  output logic             wrap
);

  mode_t            mode_sel;
  phase_t           phase_q;
  phase_t           phase_d;
  logic [WIDTH-1:0] count_d;
  logic             wrap_d;
  logic [WIDTH-1:0] step_count;
  logic             step_wrap;

  assign mode_sel = mode_t'(mode);

  jerky_step #(
    .WIDTH (WIDTH),
    .JUMP  (JUMP),
    .BACK  (BACK)
  ) u_step (
    .count        (count),
    .mode         (mode_sel),
    .phase        (phase_q),
    .next_count_c (step_count),
    .next_wrap_c  (step_wrap)
  );

  // Priority load > enable > idle; leaving jerky mode always rearms a forward step.
  always_comb begin
    count_d = count;
    phase_d = phase_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_val;
      phase_d = PH_FWD;
    end else begin
      if (mode_sel != MODE_JERKY) begin
        phase_d = PH_FWD;
      end else if (en) begin
        phase_d = (phase_q == PH_FWD) ? PH_BACK : PH_FWD;
      end
      if (en) begin
        count_d = step_count;
        wrap_d  = step_wrap;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      phase_q <= PH_FWD;
      wrap    <= 1'b0;
    end else begin
      count   <= count_d;
      phase_q <= phase_d;
      wrap    <= wrap_d;
    end
  end

  assign phase = phase_q;

endmodule
